// File: rtl/down_sample.sv
// Binarized 112x112 -> 28x28 down-sampler: one output bit per 4x4 block (count >= THRESH).
// Define DOWN_MAXPOOL_EN to make each output the OR of its block instead of a threshold.
module down_sample #(
    parameter int THRESH = 8
) (
    input  logic       sclk,
    input  logic       s_rst_n,
    input  logic       pix_data,
    input  logic       pix_valid,
    input  logic       pix_sof,
    output logic       dowm_data,
    output logic       dowm_data_valid,
    output logic [6:0] dowm_col_cnt,
    output logic [6:0] dowm_row_cnt,
    output logic       frame_done,
    output logic       busy
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [6:0] LP_LAST    = 7'd111;
    localparam logic [4:0] LP_THRESH  = 5'(THRESH);

    state_t     r_state;
    state_t     w_next_state;
    logic [6:0] r_in_col;
    logic [6:0] r_in_row;
    logic [4:0] r_acc [28];

    logic       w_start;
    logic       w_accept;
    logic [6:0] w_col;
    logic [6:0] w_row;
    logic       w_last;
    logic       w_blk_first;
    logic       w_blk_done;
    logic [4:0] w_sum;

    function automatic logic f_decide(input logic [4:0] sum);
`ifdef DOWN_MAXPOOL_EN
        return (sum != 5'd0);
`else
        return (sum >= LP_THRESH);
`endif
    endfunction

    // A sof pixel is always taken as (0,0), which also abandons any frame in progress.
    always_comb begin
        w_start     = pix_valid & pix_sof;
        w_accept    = w_start | (pix_valid & (r_state == RUN));
        w_col       = w_start ? 7'd0 : r_in_col;
        w_row       = w_start ? 7'd0 : r_in_row;
        w_last      = w_accept && (w_col == LP_LAST) && (w_row == LP_LAST);
        w_blk_first = (w_row[1:0] == 2'd0) && (w_col[1:0] == 2'd0);
        w_blk_done  = w_accept && (w_row[1:0] == 2'd3) && (w_col[1:0] == 2'd3);
        w_sum       = r_acc[w_col[6:2]] + {4'd0, pix_data};
    end

    always_comb begin
        w_next_state = r_state;
        busy         = (r_state == RUN);
        case (r_state)
            IDLE:    if (w_start) w_next_state = RUN;
            RUN:     if (w_last)  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_in_col <= '0;
            r_in_row <= '0;
            for (int i = 0; i < 28; i++) begin
                r_acc[i] <= '0;
            end
        end else if (w_accept) begin
            if (w_col == LP_LAST) begin
                r_in_col <= '0;
                r_in_row <= (w_row == LP_LAST) ? 7'd0 : w_row + 7'd1;
            end else begin
                r_in_col <= w_col + 7'd1;
                r_in_row <= w_row;
            end
            r_acc[w_col[6:2]] <= w_blk_first ? {4'd0, pix_data} : w_sum;
        end
    end

    // Output stage: one cycle after the pixel that completes a block.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            dowm_data       <= 1'b0;
            dowm_data_valid <= 1'b0;
            dowm_col_cnt    <= '0;
            dowm_row_cnt    <= '0;
            frame_done      <= 1'b0;
        end else begin
            dowm_data_valid <= w_blk_done;
            frame_done      <= w_blk_done && w_last;
            if (w_blk_done) begin
                dowm_data    <= f_decide(w_sum);
                dowm_col_cnt <= {2'b00, w_col[6:2]};
                dowm_row_cnt <= {2'b00, w_row[6:2]};
            end
        end
    end

endmodule
